// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one SRAM port between two requesters (port 0: block load/dump
// sequencer, port 1: cipher datapath). Round-robin grant, fixed wait-state
// strobe sequencing, registered per-port read data and a one-cycle ack.
//
// Ports:
//   clk, n_rst                   clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN        request and operands, held until ackN
//   ackN                         one-cycle completion pulse
//   rdataN                       last read data for that port
//   errN                         one-cycle misaligned-address pulse
//   sram_read/sram_write         SRAM strobes (only in ACCESS, never both)
//   sram_addr/sram_wdata         latched address / write data
//   sram_rdata                   SRAM read data
//   busy                         high whenever the FSM is not in IDLE
//
// Optional feature: define SRAM_ARB_ALIGN_CHECK_EN to reject addresses whose
// low four bits are nonzero (ack+err, no SRAM access). Undefined: err0/err1
// are tied low and every request reaches the SRAM.

module sram_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 128,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    // Keep at least one bit so a 1/1 latency build still has a legal counter.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, ERROR} state_e;

    state_e              state_q, state_d;
    logic                ptr_q;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    logic                grant_vld, grant_sel;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                misalign;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant_vld = req0 | req1;
        if (req0 && req1) grant_sel = ptr_q;
        else              grant_sel = req1;
    end

    assign sel_we    = grant_sel ? we1    : we0;
    assign sel_addr  = grant_sel ? addr1  : addr0;
    assign sel_wdata = grant_sel ? wdata1 : wdata0;

`ifdef SRAM_ARB_ALIGN_CHECK_EN
    assign misalign = (sel_addr[3:0] != 4'd0);
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = misalign ? ERROR : ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latch, wait-state counter and read-data capture
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state_q == IDLE && grant_vld) begin
                owner_q <= grant_sel;
                ptr_q   <= ~grant_sel;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                cnt_q   <= sel_we ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
            end else if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Sample on the last strobe cycle, after the full read latency.
            if (state_q == ACCESS && cnt_q == '0 && !we_q) begin
                if (owner_q) rdata1_q <= sram_rdata;
                else         rdata0_q <= sram_rdata;
            end
        end
    end

    // Outputs are decoded from state only, so reset drops strobes at once.
    always_comb begin
        sram_read  = 1'b0;
        sram_write = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        case (state_q)
            ACCESS: begin
                sram_read  = ~we_q;
                sram_write = we_q;
            end
            RECOVER: begin
                ack0 = ~owner_q;
                ack1 = owner_q;
            end
            ERROR: begin
                ack0 = ~owner_q;
                ack1 = owner_q;
`ifdef SRAM_ARB_ALIGN_CHECK_EN
                err0 = ~owner_q;
                err1 = owner_q;
`endif
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a cycle-by-cycle vector table
// (inputs for the cycle, expected outputs in that cycle) plus a hand-written
// reset-during-access sequence. A small behavioural SRAM sits on the far side.

module tb_sram_port_arbiter;

    localparam logic [127:0] D1  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] D2  = 128'hAABBCCDDEEFF00998877665544332211;
    localparam logic [127:0] DF  = {128{1'b1}};
    localparam logic [127:0] M32 = {4{32'hC0DE0002}};

    // Flag vector: {sram_read, sram_write, ack0, ack1, err0, err1, busy}
    localparam logic [6:0] IDL = 7'b0000000;
    localparam logic [6:0] RD  = 7'b1000001;
    localparam logic [6:0] WR  = 7'b0100001;
    localparam logic [6:0] A0  = 7'b0010001;
    localparam logic [6:0] A1  = 7'b0001001;
    localparam logic [6:0] E1  = 7'b0001011;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         req0, we0, req1, we1;
    logic [15:0]  addr0, addr1;
    logic [127:0] wdata0, wdata1;
    logic         ack0, ack1, err0, err1;
    logic [127:0] rdata0, rdata1;
    logic         sram_read, sram_write, busy;
    logic [15:0]  sram_addr;
    logic [127:0] sram_wdata, sram_rdata;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W(16), .DATA_W(128), .READ_LAT(2), .WRITE_LAT(1)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .sram_read(sram_read), .sram_write(sram_write),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .busy(busy)
    );

    // 16-word SRAM model, one word per 16-byte line.
    logic [127:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = {4{32'hC0DE0000 | 32'(i)}};
    always @(posedge clk) if (sram_write) mem[sram_addr[7:4]] <= sram_wdata;
    assign sram_rdata = mem[sram_addr[7:4]];

    typedef struct {
        logic         r0, w0;
        logic [15:0]  a0;
        logic [127:0] d0;
        logic         r1, w1;
        logic [15:0]  a1;
        logic [127:0] d1;
        logic [6:0]   fl;
        logic [15:0]  sa;
        logic [127:0] swd, x0, x1;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic add(input logic r0, w0, input logic [15:0] a0, input logic [127:0] d0,
                       input logic r1, w1, input logic [15:0] a1, input logic [127:0] d1,
                       input logic [6:0] fl, input logic [15:0] sa,
                       input logic [127:0] swd, x0, x1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.fl = fl; v.sa = sa; v.swd = swd; v.x0 = x0; v.x1 = x1;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [6:0] flags();
        return {sram_read, sram_write, ack0, ack1, err0, err1, busy};
    endfunction

    initial begin
        n_rst = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

        //   r0 w0 a0  d0   r1 w1 a1  d1   flags sa  swd x0  x1
        // port 0 write addr 0, WRITE_LAT=1
        add(1, 1, 0,  D1,  0, 0, 0,  0,   IDL,  0,  0,  0,  0);
        add(1, 1, 0,  D1,  0, 0, 0,  0,   WR,   0,  D1, 0,  0);
        add(0, 0, 0,  0,   0, 0, 0,  0,   A0,   0,  D1, 0,  0);
        // port 1 read addr 0, READ_LAT=2
        add(0, 0, 0,  0,   1, 0, 0,  0,   IDL,  0,  D1, 0,  0);
        add(0, 0, 0,  0,   1, 0, 0,  0,   RD,   0,  0,  0,  0);
        add(0, 0, 0,  0,   1, 0, 0,  0,   RD,   0,  0,  0,  0);
        add(0, 0, 0,  0,   0, 0, 0,  0,   A1,   0,  0,  0,  D1);
        // simultaneous: pointer at port 0, port 0 first, port 1 stays pending
        add(1, 1, 16, DF,  1, 0, 32, 0,   IDL,  0,  0,  0,  D1);
        add(1, 1, 16, DF,  1, 0, 32, 0,   WR,   16, DF, 0,  D1);
        add(0, 0, 0,  0,   1, 0, 32, 0,   A0,   16, DF, 0,  D1);
        add(0, 0, 0,  0,   1, 0, 32, 0,   IDL,  16, DF, 0,  D1);
        add(0, 0, 0,  0,   1, 0, 32, 0,   RD,   32, 0,  0,  D1);
        add(0, 0, 0,  0,   1, 0, 32, 0,   RD,   32, 0,  0,  D1);
        add(0, 0, 0,  0,   0, 0, 0,  0,   A1,   32, 0,  0,  M32);
        // port 0 write then read addr 32; new operands presented in the ack cycle
        add(1, 1, 32, D2,  0, 0, 0,  0,   IDL,  32, 0,  0,  M32);
        add(1, 1, 32, D2,  0, 0, 0,  0,   WR,   32, D2, 0,  M32);
        add(1, 0, 32, D2,  0, 0, 0,  0,   A0,   32, D2, 0,  M32);
        add(1, 0, 32, D2,  0, 0, 0,  0,   IDL,  32, D2, 0,  M32);
        add(1, 0, 32, D2,  0, 0, 0,  0,   RD,   32, D2, 0,  M32);
        add(1, 0, 32, D2,  0, 0, 0,  0,   RD,   32, D2, 0,  M32);
        add(0, 0, 0,  0,   0, 0, 0,  0,   A0,   32, D2, D2, M32);
        // simultaneous again: pointer now at port 1, port 1 first
        add(1, 0, 16, 0,   1, 0, 16, 0,   IDL,  32, D2, D2, M32);
        add(1, 0, 16, 0,   1, 0, 16, 0,   RD,   16, 0,  D2, M32);
        add(1, 0, 16, 0,   1, 0, 16, 0,   RD,   16, 0,  D2, M32);
        add(1, 0, 16, 0,   0, 0, 0,  0,   A1,   16, 0,  D2, DF);
        add(1, 0, 16, 0,   0, 0, 0,  0,   IDL,  16, 0,  D2, DF);
        add(1, 0, 16, 0,   0, 0, 0,  0,   RD,   16, 0,  D2, DF);
        add(1, 0, 16, 0,   0, 0, 0,  0,   RD,   16, 0,  D2, DF);
        add(0, 0, 0,  0,   0, 0, 0,  0,   A0,   16, 0,  DF, DF);
        // port 1 reads misaligned addr 8
        add(0, 0, 0,  0,   1, 0, 8,  0,   IDL,  16, 0,  DF, DF);
`ifdef SRAM_ARB_ALIGN_CHECK_EN
        add(0, 0, 0,  0,   0, 0, 0,  0,   E1,   8,  0,  DF, DF);
        add(0, 0, 0,  0,   0, 0, 0,  0,   IDL,  8,  0,  DF, DF);
`else
        add(0, 0, 0,  0,   1, 0, 8,  0,   RD,   8,  0,  DF, DF);
        add(0, 0, 0,  0,   1, 0, 8,  0,   RD,   8,  0,  DF, DF);
        add(0, 0, 0,  0,   0, 0, 0,  0,   A1,   8,  0,  DF, D1);
        add(0, 0, 0,  0,   0, 0, 0,  0,   IDL,  8,  0,  DF, D1);
`endif

        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        foreach (vq[i]) begin
            req0 = vq[i].r0; we0 = vq[i].w0; addr0 = vq[i].a0; wdata0 = vq[i].d0;
            req1 = vq[i].r1; we1 = vq[i].w1; addr1 = vq[i].a1; wdata1 = vq[i].d1;
            @(negedge clk);
            chk($sformatf("c%0d flags", i), 128'(flags()), 128'(vq[i].fl));
            chk($sformatf("c%0d sram_addr", i), 128'(sram_addr), 128'(vq[i].sa));
            chk($sformatf("c%0d sram_wdata", i), sram_wdata, vq[i].swd);
            chk($sformatf("c%0d rdata0", i), rdata0, vq[i].x0);
            chk($sformatf("c%0d rdata1", i), rdata1, vq[i].x1);
            @(posedge clk);
            #1;
        end

        // Reset in the second cycle of a READ_LAT=2 read.
        req1 = 1; we1 = 0; addr1 = 16'h0010;
        @(posedge clk);            // grant
        #1 chk("abort first rd cycle", 128'(sram_read), 128'(1));
        @(posedge clk);            // second read cycle
        #1 chk("abort second rd cycle", 128'(sram_read), 128'(1));
        #1 n_rst = 1'b0;
        #1;
        req1 = 0;
        chk("abort flags", 128'(flags()), 128'(IDL));
        chk("abort sram_addr", 128'(sram_addr), 128'(0));
        chk("abort sram_wdata", sram_wdata, 128'(0));
        chk("abort rdata0", rdata0, 128'(0));
        chk("abort rdata1", rdata1, 128'(0));
        @(negedge clk);
        chk("abort no ack", 128'({ack0, ack1}), 128'(0));
        @(posedge clk);
        #1 n_rst = 1'b1;

        // Next request after reset is served normally.
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        begin
            int  rdc;
            bit  got;
            rdc = 0;
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (sram_read) rdc++;
                if (ack0) begin
                    got  = 1;
                    req0 = 0;
                end
            end
            chk("post-reset ack0 seen", 128'(got), 128'(1));
            chk("post-reset read cycles", 128'(rdc), 128'(2));
            chk("post-reset rdata0", rdata0, DF);
            chk("post-reset rdata1", rdata1, 128'(0));
        end
        @(negedge clk);
        chk("post-reset busy", 128'(busy), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
